// File: rtl/div_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_defs (package)
// Brief    : Shared divider constants and FSM state encodings
// Revision : 1.0  initial release
// ============================================================================
package div_defs;

    localparam int c_width = 32;
    localparam int c_iters = 32;
    localparam int c_cnt_w = 5;

    localparam logic [c_cnt_w-1:0] c_last_iter = 5'd31;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Brief    : One combinational radix-2 restoring division step
// Revision : 1.0  initial release
// ============================================================================
import div_defs::*;

module div_step #(
    parameter int WIDTH = c_width
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_out,
    output logic             qbit
);

    logic w_ge;

    // rem_in is already shifted, so it may carry one bit above WIDTH
    assign w_ge    = (rem_in >= {1'b0, dvsr});
    assign qbit    = w_ge;
    assign rem_out = w_ge ? WIDTH'(rem_in - {1'b0, dvsr}) : rem_in[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : Multi-cycle signed/unsigned divider, one quotient bit per cycle
// Revision : 1.0  initial release
// ============================================================================
import div_defs::*;

module div_unit #(
    parameter int WIDTH = c_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    logic [0:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_dvsr;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_dz;
    logic               r_done;

    logic               w_accept;
    logic               w_last;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_step_in;
    logic [WIDTH-1:0]   w_rem_next;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_quot_next;
    logic [WIDTH-1:0]   w_q_fin;
    logic [WIDTH-1:0]   w_r_fin;

    assign w_accept = start && (r_state == c_st_idle);
    assign w_last   = (r_state == c_st_run) && (r_cnt == c_last_iter);

    // Magnitudes stay unsigned so the most negative value negates to itself
    assign w_a_neg = is_signed & dividend[WIDTH-1];
    assign w_b_neg = is_signed & divisor[WIDTH-1];
    assign w_a_mag = w_a_neg ? -dividend : dividend;
    assign w_b_mag = w_b_neg ? -divisor  : divisor;

    assign w_step_in = {r_rem, r_quot[WIDTH-1]};

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (w_step_in),
        .dvsr    (r_dvsr),
        .rem_out (w_rem_next),
        .qbit    (w_qbit)
    );

    assign w_quot_next = {r_quot[WIDTH-2:0], w_qbit};

    assign w_q_fin = r_dz    ? '1         :
                     r_q_neg ? -w_quot_next : w_quot_next;
    assign w_r_fin = r_dz    ? r_dividend :
                     r_r_neg ? -w_rem_next  : w_rem_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_dvsr     <= '0;
            r_dividend <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_dz       <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_state    <= c_st_run;
                r_cnt      <= '0;
                r_rem      <= '0;
                r_quot     <= w_a_mag;
                r_dvsr     <= w_b_mag;
                r_dividend <= dividend;
                r_q_neg    <= w_a_neg ^ w_b_neg;
                r_r_neg    <= w_a_neg;
                r_dz       <= (divisor == '0);
            end else if (r_state == c_st_run) begin
                r_rem  <= w_rem_next;
                r_quot <= w_quot_next;
                r_cnt  <= r_cnt + c_cnt_w'(1);
                // q/r only change here, so partial results never leak out
                if (w_last) begin
                    r_state <= c_st_idle;
                    r_done  <= 1'b1;
                    r_q     <= w_q_fin;
                    r_r     <= w_r_fin;
                end
            end
        end
    end

    assign q        = r_q;
    assign r        = r_r;
    assign busy     = (r_state == c_st_run);
    assign done     = r_done;
    assign div_zero = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Brief    : Scoreboard bench for div_unit
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps

module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;
    logic        div_zero;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .q         (q),
        .r         (r),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] hold_q = '0;
    logic [31:0] hold_r = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t        e;
        logic        an;
        logic        bn;
        logic [31:0] am;
        logic [31:0] bm;
        an = s & a[31];
        bn = s & b[31];
        am = an ? -a : a;
        bm = bn ? -b : b;
        e.acc = 0;
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = am / bm;
            e.r  = am % bm;
            if (an ^ bn) e.q = -e.q;
            if (an)      e.r = -e.r;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Caller is positioned at a negedge; start is accepted at the next posedge
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz);
        exp_t e;
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        e.q   = eq;
        e.r   = er;
        e.dz  = edz;
        e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || sb.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check_val("timeout_idle", 32'(k), 32'd0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check_val("spurious_done", {31'b0, done}, 32'd0);
                end else begin
                    m_e = sb.pop_front();
                    check_val("q", q, m_e.q);
                    check_val("r", r, m_e.r);
                    check_val("div_zero", {31'b0, div_zero}, {31'b0, m_e.dz});
                    check_val("busy_at_done", {31'b0, busy}, 32'd0);
                    check_val("latency", 32'(cyc - m_e.acc), 32'd32);
                    hold_q = m_e.q;
                    hold_r = m_e.r;
                end
            end else if (busy) begin
                check_val("q_hold", q, hold_q);
                check_val("r_hold", r, hold_r);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   k;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;

        #1 rst = 1'b1;
        #20;
        check_val("rst_q", q, 32'd0);
        check_val("rst_r", r, 32'd0);
        check_val("rst_busy", {31'b0, busy}, 32'd0);
        check_val("rst_done", {31'b0, done}, 32'd0);
        check_val("rst_dz", {31'b0, div_zero}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        wait_idle();

        issue(-32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        issue(32'd7, -32'sd2, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
        wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0);
        wait_idle();
        issue(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        wait_idle();
        issue(-32'sd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
        wait_idle();

        // Mid-run start must be ignored; start during done must be taken
        issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check_val("timeout_done", 32'(k), 32'd0);
        issue(32'd77, 32'd5, 1'b0, 32'd15, 32'd2, 1'b0);
        wait_idle();

        // Reset in the middle of a run
        issue(32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("midrst_busy", {31'b0, busy}, 32'd0);
        check_val("midrst_q", q, 32'd0);
        check_val("midrst_r", r, 32'd0);
        check_val("midrst_done", {31'b0, done}, 32'd0);
        sb.delete();
        hold_q = '0;
        hold_r = '0;
        @(negedge clk);
        rst = 1'b0;
        issue(32'd20, 32'd3, 1'b0, 32'd6, 32'd2, 1'b0);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
            s = 1'($urandom_range(0, 1));
            e = model(a, b, s);
            issue(a, b, s, e.q, e.r, e.dz);
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
